// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder reused over WIDTH cycles, LSB first,
// with valid/ready handshakes on the operand and result sides.

module bit_serial_full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module bit_serial_adder_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q,    sum_sh_d;
    logic               carry_q,     carry_d;
    logic               overflow_q,  overflow_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic fa_s;
    logic fa_c;

    bit_serial_full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                    a_sh_d     = op_a;
                    b_sh_d     = sub ? ~op_b : op_b;
                    carry_d    = sub;
                    cnt_d      = '0;
                    sum_sh_d   = '0;
                    overflow_d = 1'b0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = fa_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q is the carry into the MSB, fa_c the carry out of it.
                    overflow_d  = carry_q ^ fa_c;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_sh_q;
    assign c_out     = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench for bit_serial_adder_ctrl (WIDTH=8): directed arithmetic cases,
// backpressure, mid-operation reset and randomized back-to-back traffic against an arithmetic model.

module tb_bit_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         overflow;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serial_adder_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {overflow, c_out, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int ua, ub, sa, sb, ru, rs;
        logic [W-1:0] r;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ru = s ? (ua - ub) : (ua + ub);
        rs = s ? (sa - sb) : (sa + sb);
        r  = W'(ru & ((1 << W) - 1));
        c  = s ? (ua >= ub) : (ru >= (1 << W));
        v  = (rs > ((1 << (W - 1)) - 1)) || (rs < -(1 << (W - 1)));
        return {v, c, r};
    endfunction

    // Presents an op (all steps at negedges) and returns once the accept edge has passed.
    task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output bit ok);
        ok       = 1'b0;
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        sub      = 1'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result(output logic [W-1:0] s_o, output logic c_o, output logic v_o, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        s_o = sum;
        c_o = c_out;
        v_o = overflow;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        op_a      = 8'h11;
        op_b      = 8'h22;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_handshake: got in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
        end
        n_checks++;
        if ({sum, c_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got sum=%h c=%b v=%b required all zero", sum, c_out, overflow);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_accept: got busy=%b in_ready=%b required 0/1", busy, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5], vb[5], vsum[5];
        logic         vs[5], vc[5], vv[5];
        logic [W-1:0] gs;
        logic         gc, gv;
        int           lat;
        bit           ok;
        va[0] = 8'h5A; vb[0] = 8'h3C; vs[0] = 0; vsum[0] = 8'h96; vc[0] = 0; vv[0] = 1;
        va[1] = 8'hFF; vb[1] = 8'h01; vs[1] = 0; vsum[1] = 8'h00; vc[1] = 1; vv[1] = 0;
        va[2] = 8'h7F; vb[2] = 8'h01; vs[2] = 0; vsum[2] = 8'h80; vc[2] = 0; vv[2] = 1;
        va[3] = 8'h10; vb[3] = 8'h20; vs[3] = 1; vsum[3] = 8'hF0; vc[3] = 0; vv[3] = 0;
        va[4] = 8'h80; vb[4] = 8'h01; vs[4] = 1; vsum[4] = 8'h7F; vc[4] = 1; vv[4] = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            accept_op(va[i], vb[i], vs[i], ok);
            n_checks++;
            if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_accept[%0d]: got ok=%b busy=%b in_ready=%b required 1/1/0", i, ok, busy, in_ready);
            end
            wait_result(gs, gc, gv, lat);
            n_checks++;
            if (lat !== W) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, W);
            end
            n_checks++;
            if ({gs, gc, gv} !== {vsum[i], vc[i], vv[i]}) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got sum=%h c=%b v=%b required sum=%h c=%b v=%b",
                         i, gs, gc, gv, vsum[i], vc[i], vv[i]);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_release[%0d]: got out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, pa, pb, gs;
        logic         s, ps, gc, gv;
        logic [W+1:0] exp_r, exp_p;
        int           lat, bad;
        bit           ok;
        a = W'($urandom); b = W'($urandom); s = 1'($urandom);
        pa = W'($urandom); pb = W'($urandom); ps = 1'($urandom);
        exp_r = model(a, b, s);
        exp_p = model(pa, pb, ps);
        out_ready = 1'b0;
        accept_op(a, b, s, ok);
        wait_result(gs, gc, gv, lat);
        n_checks++;
        if (!ok || lat !== W || {gv, gc, gs} !== exp_r) begin
            n_fail++;
            $display("FAIL bp_result: got ok=%b lat=%0d {v,c,sum}=%h required lat=%0d %h", ok, lat, {gv, gc, gs}, W, exp_r);
        end
        op_a = pa; op_b = pb; sub = ps; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || {overflow, c_out, sum} !== exp_r)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles required 0", bad);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_pending_accept: got busy=%b required 1", busy);
        end
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
        wait_result(gs, gc, gv, lat);
        n_checks++;
        if (lat !== W || {gv, gc, gs} !== exp_p) begin
            n_fail++;
            $display("FAIL bp_pending_result: got lat=%0d %h required lat=%0d %h", lat, {gv, gc, gs}, W, exp_p);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] gs;
        logic         gc, gv;
        int           lat, seen;
        bit           ok;
        out_ready = 1'b1;
        accept_op(8'h5A, 8'h3C, 1'b0, ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, busy, sum, c_out, overflow} !== {3'b100, 10'b0}) begin
            n_fail++;
            $display("FAIL midrst_outputs: got in_ready=%b out_valid=%b busy=%b sum=%h c=%b v=%b required reset values",
                     in_ready, out_valid, busy, sum, c_out, overflow);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrst_no_valid: got %0d out_valid cycles required 0", seen);
        end
        accept_op(8'h01, 8'h02, 1'b0, ok);
        wait_result(gs, gc, gv, lat);
        n_checks++;
        if (!ok || lat !== W || {gs, gc, gv} !== {8'h03, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_next_op: got ok=%b lat=%0d sum=%h c=%b v=%b required lat=%0d sum=03 c=0 v=0",
                     ok, lat, gs, gc, gv, W);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[16], qb[16];
        logic         qs[16];
        int           acc_cyc[16];
        int           issued, got, cyc;
        logic [W+1:0] exp_r;
        for (int i = 0; i < 16; i++) begin
            qa[i] = W'($urandom);
            qb[i] = W'($urandom);
            qs[i] = 1'($urandom);
        end
        issued    = 0;
        got       = 0;
        cyc       = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (got < 16 && cyc < 400) begin
            if (out_valid === 1'b1) begin
                exp_r = model(qa[got], qb[got], qs[got]);
                n_checks++;
                if ({overflow, c_out, sum} !== exp_r || cyc - acc_cyc[got] != W + 1) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got {v,c,sum}=%h after %0d cycles required %h after %0d",
                             got, {overflow, c_out, sum}, cyc - acc_cyc[got], exp_r, W + 1);
                end
                got++;
            end
            if (in_ready === 1'b1 && issued < 16) begin
                op_a = qa[issued];
                op_b = qb[issued];
                sub  = qs[issued];
                acc_cyc[issued] = cyc;
                issued++;
            end else if (issued == 16) begin
                in_valid = 1'b0;
            end else begin
                op_a = W'($urandom);
                op_b = W'($urandom);
                sub  = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 16) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d results required 16", got);
        end
        for (int i = 1; i < issued; i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
                n_fail++;
                $display("FAIL b2b_interval[%0d]: got %0d required %0d", i, acc_cyc[i] - acc_cyc[i-1], W + 2);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
